i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) responder with a small byte-wide register file, the bus-side counterpart of the APB-to-I2C master. It sits on the same open-drain `sda`/`scl` wires as the master, and in the verification environment serves as the addressable endpoint for master write/read transfers. All logic runs on `core_clk`. SCL/SDA are oversampled, and the block never drives SCL.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h50: 7-bit address this target answers to.
- `DEPTH`, 8: number of 8-bit registers; power of two, 2..256.

Ports:
- `core_clk`  in  1: sole clock; must be at least 8× the SCL frequency.
- `PRESETn`  in  1: reset, asynchronous and active-low.
- `scl_i`  in  1: SCL as seen on the wire.
- `sda_i`  in  1: SDA as seen on the wire.
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release.
- `wr_strobe`  out  1: one-cycle pulse when a data byte is written into the register file.
- `wr_addr`  out  $clog2(DEPTH): register index for `wr_strobe`.
- `wr_data`  out  8: byte for `wr_strobe`.
- `busy`  out  1: 1 from a START addressed to this target until STOP, or until a START addressed elsewhere.

## Operation
- Input conditioning: 2-flop synchronizer on `scl_i` and `sda_i`. This is followed by an edge detector on the synchronized values.
- START condition: SDA falls while SCL is high. STOP condition: SDA rises while SCL is high. Both are detected in every state.
- START or repeated START moves the FSM to ADDR from any state. STOP moves it to IDLE from any state.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: shift 8 bits MSB-first, sampling on each SCL rising edge.
  - Bits[7:1] == `TARGET_ADDR` → ADDR_ACK.
  - Otherwise → IGNORE, with SDA released until the next START or STOP.
- ADDR_ACK: drive `sda_oe`=1 for the 9th clock.
  - R/W=0 → PTR.
  - R/W=1 → RD_DATA.
- PTR: the first written byte loads the register pointer, modulo DEPTH. Then PTR_ACK (ACK) → WR_DATA.
- WR_DATA: the received byte is written to reg[ptr]. `wr_strobe` pulses with `wr_addr`=ptr. ptr increments, wrapping DEPTH-1→0. Then WR_ACK (ACK) → WR_DATA.
- RD_DATA: output reg[ptr] MSB-first. Bit k=0 → `sda_oe`=1; bit k=1 → `sda_oe`=0. ptr increments after the 8th bit. Then RD_ACK: release SDA and sample the master's bit.
  - ACK (0) → RD_DATA.
  - NACK (1) → IGNORE.
- The pointer persists across transfers. A read without a preceding pointer write starts at the current pointer.
- Register file contents are updated only by I2C writes.

## Timing
- Reset values:
  - `sda_oe`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - FSM=IDLE, ptr=0, all registers 8'h00.
- Drive changes (ACK assert/release, read bits) happen on the core_clk cycle after the synchronized SCL falling edge is detected. They never change while SCL is high.
- Sampling happens on the core_clk cycle after the synchronized SCL rising edge is detected. Latency from the pin is 3 core_clk cycles, or 5 with the filter described under Configuration.
- `wr_strobe` asserts 1 cycle after the 8th data bit is sampled, before the ACK falling edge.
- START/STOP during the ACK phase or mid-byte:
  - `sda_oe` drops the same cycle.
  - A partial byte is discarded, with no `wr_strobe`.
- `PRESETn` asserted mid-transfer: all outputs immediately take their reset values, with SDA released.

## Configuration
- Macro `I2C_TARGET_GLITCH_FILTER_EN`.
- Defined: a 3-sample majority filter follows each synchronizer. Pulses of 1 core_clk cycle are suppressed, and sampling latency grows by 2 cycles.
- Undefined: no filter; synchronizer output is used directly.

## Test plan
- Write: START, 0xA0, ptr 0x02, data 0x5A, 0xC3, STOP.
  - ACK on all 4 bytes.
  - `wr_strobe` pulses with (2,0x5A) then (3,0xC3).
  - `busy` deasserts after STOP.
- Read with repeated START: START, 0xA0, ptr 0x02, Sr, 0xA1, master ACK then NACK.
  - SDA returns 0x5A then 0xC3.
  - FSM goes to IGNORE, then IDLE after STOP.
- Wrong address 0xA2: no ACK (`sda_oe` stays 0 throughout), no strobe, `busy`=0.
- Pointer wrap (DEPTH=8): ptr 0x07, write 0x11, 0x22 → strobes at index 7, then index 0.
- STOP after 4 data bits: no `wr_strobe`, `sda_oe`=0. A following full write still works.
- `PRESETn` pulse during a read data bit: `sda_oe`=0 immediately, ptr=0, registers read back 0x00.
- With `I2C_TARGET_GLITCH_FILTER_EN`: a 1-cycle SCL glitch mid-byte causes no extra bit shift, and the byte is received correctly.

Source files
------------

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target (slave) with a small byte-wide register file. It sits on the
// open-drain SDA/SCL wires next to the master and answers transfers that
// carry address TARGET_ADDR:
//   write : START, {addr,0}, pointer byte, data bytes..., STOP
//   read  : START, {addr,1}, data bytes (from reg[ptr]...), master NACK, STOP
// The pointer persists across transfers and wraps modulo DEPTH. SCL is
// never driven; SDA is only ever pulled low through sda_oe.
//
// Parameters
//   TARGET_ADDR  7-bit bus address this target answers to
//   DEPTH        number of 8-bit registers (power of two, 2..256)
//
// Ports
//   core_clk   in   sole clock, at least 8x the SCL frequency
//   PRESETn    in   asynchronous active-low reset
//   scl_i      in   SCL as seen on the wire
//   sda_i      in   SDA as seen on the wire
//   sda_oe     out  1 = pull SDA low, 0 = release
//   wr_strobe  out  one-cycle pulse when a data byte lands in the register file
//   wr_addr    out  register index for wr_strobe
//   wr_data    out  byte for wr_strobe
//   busy       out  1 from an address match until STOP or a START for
//                   another target
//
// Build option
//   I2C_TARGET_GLITCH_FILTER_EN  when defined, a 3-sample majority filter
//   follows each synchronizer: single-cycle pulses are suppressed and the
//   sampling latency grows by two core_clk cycles.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         DEPTH       = 8,
  localparam int        AW          = $clog2(DEPTH)
) (
  input  logic          core_clk,
  input  logic          PRESETn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WR_DATA  = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_IGNORE   = 4'd9;

  localparam logic [AW-1:0] PTR_ONE = 1;

  // -------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers (optionally a majority filter),
  // then a one-cycle history for edge and START/STOP detection. Everything
  // resets to 1, the idle bus level, so reset release creates no edges.
  // -------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_c, sda_c;
  logic scl_prev_q, sda_prev_q;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the pre-edge values, exactly like the hardware they describe.
  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_flt_q, sda_flt_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_flt_q <= 3'b111;
      sda_flt_q <= 3'b111;
    end else begin
      scl_flt_q <= {scl_flt_q[1:0], scl_s2_q};
      sda_flt_q <= {sda_flt_q[1:0], sda_s2_q};
    end
  end

  // A new level wins only after it occupies two of the three taps.
  assign scl_c = maj3(scl_flt_q);
  assign sda_c = maj3(sda_flt_q);
`else
  assign scl_c = scl_s2_q;
  assign sda_c = sda_s2_q;
`endif

  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  // SDA may only move while SCL is high for START/STOP; SCL must be high on
  // both samples so an SCL edge coinciding with an SDA change is not taken.
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  // -------------------------------------------------------------------------
  // Protocol FSM. Bits are sampled on SCL rising edges; SDA drive changes on
  // SCL falling edges only. bit_cnt runs 0..7 for the byte, 8 between the
  // 8th and 9th rising edges, 9 between the 9th rising and falling edges.
  // -------------------------------------------------------------------------
  logic [3:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          mem_we;

  logic [7:0] regs_q [DEPTH];
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  assign byte_in = {shift_q[6:0], sda_c};
  assign rd_byte = regs_q[ptr_q];

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      // busy stays as is until the address byte says who is addressed.
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              S_ADDR: begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  state_d = S_ADDR_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end
              S_PTR: begin
                ptr_d   = byte_in[AW-1:0];
                state_d = S_PTR_ACK;
              end
              default: begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_q + PTR_ONE;
                state_d     = S_WR_ACK;
              end
            endcase
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (bit_cnt_q == 4'd8) bit_cnt_d = 4'd9;
        end
        S_RD_DATA: begin
          // Left shift so the next bit to drive always sits in shift_q[7].
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            ptr_d   = ptr_q + PTR_ONE;
            state_d = S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (bit_cnt_q == 4'd8) begin
            if (sda_c) state_d = S_IGNORE;   // master NACK ends the read
            else       bit_cnt_d = 4'd9;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
          end else if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              // First read bit goes out on the same falling edge that ends ACK.
              state_d  = S_RD_DATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_RD_DATA: sda_oe_d = ~shift_q[7];
        S_RD_ACK: begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else if (bit_cnt_q == 4'd9) begin
            state_d   = S_RD_DATA;
            bit_cnt_d = 4'd0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // NOTE: the register file is reset explicitly because reads after reset
  // must return 8'h00; this costs a reset net on every storage flop.
  always_ff @(posedge core_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else if (mem_we) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Directed bench for i2c_target_regs. A behavioural I2C master drives SCL
// and SDA (open-drain wired with the target's sda_oe). Expected register
// writes and read bytes are queued when the stimulus is issued and popped
// when the target produces the strobe or the master finishes a read byte.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

  localparam int Q     = 8;   // core_clk cycles per quarter SCL period
  localparam int DEPTH = 8;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_IGNORE = 4'd9;

  logic       core_clk = 1'b0;
  logic       PRESETn  = 1'b0;
  logic       scl_m    = 1'b1;
  logic       sda_m    = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  wr_t        wr_e;
  logic       watch_oe = 1'b0;
  logic       oe_seen  = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 core_clk = ~core_clk;

  i2c_target_regs #(
    .TARGET_ADDR (7'h50),
    .DEPTH       (DEPTH)
  ) dut (
    .core_clk  (core_clk),
    .PRESETn   (PRESETn),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-strobe scoreboard, sampled on the falling clock edge.
  always @(negedge core_clk) begin
    if (watch_oe && sda_oe === 1'b1) oe_seen = 1'b1;
    if (PRESETn && wr_strobe === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_wr_strobe", 32'd1, 32'd0);
      end else begin
        wr_e = exp_wr.pop_front();
        check("wr_addr", {29'd0, wr_addr}, {29'd0, wr_e.addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, wr_e.data});
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge core_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    sampled = sda_line;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  // glitch_at: bit index after which a 1-cycle SCL pulse is injected (-1 none).
  task automatic write_byte(input logic [7:0] b, output logic ack, input int glitch_at);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s);
      if (i == glitch_at) begin
        scl_m = 1'b1;
        @(negedge core_clk);
        scl_m = 1'b0;
      end
    end
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_check(input logic master_ack);
    logic [7:0] b;
    logic       s;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    clock_bit(~master_ack, s);
    e = exp_rd.pop_front();
    check("rd_data", {24'd0, b}, {24'd0, e});
  endtask

  initial begin
    logic ack;
    logic s;

    // ---- reset state
    repeat (3) @(negedge core_clk);
    check("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr",   {29'd0, wr_addr},   32'd0);
    check("rst_wr_data",   {24'd0, wr_data},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_state",     {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    PRESETn = 1'b1;
    wait_q();

    // ---- write: ptr 2, data 5A, C3
    i2c_start();
    write_byte(8'hA0, ack, -1); check("w_addr_ack", {31'd0, ack}, 32'd1);
    check("w_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h02, ack, -1); check("w_ptr_ack", {31'd0, ack}, 32'd1);
    exp_wr.push_back('{3'd2, 8'h5A});
    write_byte(8'h5A, ack, -1); check("w_d0_ack", {31'd0, ack}, 32'd1);
    exp_wr.push_back('{3'd3, 8'hC3});
    write_byte(8'hC3, ack, -1); check("w_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("w_busy_after_stop", {31'd0, busy}, 32'd0);

    // ---- read with repeated START
    i2c_start();
    write_byte(8'hA0, ack, -1); check("r_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h02, ack, -1); check("r_ptr_ack", {31'd0, ack}, 32'd1);
    i2c_start();
    write_byte(8'hA1, ack, -1); check("r_addr_rd_ack", {31'd0, ack}, 32'd1);
    exp_rd.push_back(8'h5A); read_check(1'b1);
    exp_rd.push_back(8'hC3); read_check(1'b0);
    check("r_state_ignore", {28'd0, dut.state_q}, {28'd0, ST_IGNORE});
    check("r_busy_before_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    check("r_state_idle", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    check("r_busy_after_stop", {31'd0, busy}, 32'd0);

    // ---- wrong address
    oe_seen = 1'b0; watch_oe = 1'b1;
    i2c_start();
    write_byte(8'hA2, ack, -1); check("wa_no_ack", {31'd0, ack}, 32'd0);
    check("wa_busy", {31'd0, busy}, 32'd0);
    check("wa_state_ignore", {28'd0, dut.state_q}, {28'd0, ST_IGNORE});
    write_byte(8'h55, ack, -1); check("wa_data_no_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    watch_oe = 1'b0;
    check("wa_sda_oe_never", {31'd0, oe_seen}, 32'd0);

    // ---- pointer wrap at DEPTH-1
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h07, ack, -1);
    exp_wr.push_back('{3'd7, 8'h11});
    write_byte(8'h11, ack, -1);
    exp_wr.push_back('{3'd0, 8'h22});
    write_byte(8'h22, ack, -1); check("wrap_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("wrap_ptr", {29'd0, dut.ptr_q}, 32'd1);

    // ---- STOP after 4 data bits, then a full write
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h04, ack, -1);
    clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
    i2c_stop();
    check("part_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("part_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h04, ack, -1);
    exp_wr.push_back('{3'd4, 8'h77});
    write_byte(8'h77, ack, -1); check("part_next_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    // Read back regs 3 and 4 to confirm the partial byte left nothing behind.
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h03, ack, -1);
    i2c_start();
    write_byte(8'hA1, ack, -1);
    exp_rd.push_back(8'hC3); read_check(1'b1);
    exp_rd.push_back(8'h77); read_check(1'b0);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // ---- 1-cycle SCL glitch mid-byte is filtered out
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h05, ack, -1);
    exp_wr.push_back('{3'd5, 8'h96});
    write_byte(8'h96, ack, 3); check("glitch_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
`endif

    // ---- reset pulse while the target drives a 0 read bit
    i2c_start();
    write_byte(8'hA0, ack, -1);
    write_byte(8'h03, ack, -1);
    i2c_start();
    write_byte(8'hA1, ack, -1);
    clock_bit(1'b1, s); clock_bit(1'b1, s);   // C3: bits 7,6 = 1; bit 5 = 0
    check("prst_sda_oe_driving", {31'd0, sda_oe}, 32'd1);
    PRESETn = 1'b0;
    #1;
    check("prst_sda_oe",  {31'd0, sda_oe},  32'd0);
    check("prst_busy",    {31'd0, busy},    32'd0);
    check("prst_wr_addr", {29'd0, wr_addr}, 32'd0);
    check("prst_wr_data", {24'd0, wr_data}, 32'd0);
    check("prst_ptr",     {29'd0, dut.ptr_q}, 32'd0);
    @(negedge core_clk);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_q();
    PRESETn = 1'b1;
    wait_q();
    // Read without a pointer write starts at ptr 0; registers are cleared.
    i2c_start();
    write_byte(8'hA1, ack, -1); check("prst_rd_ack", {31'd0, ack}, 32'd1);
    exp_rd.push_back(8'h00); read_check(1'b1);
    exp_rd.push_back(8'h00); read_check(1'b0);
    i2c_stop();

    wait_q();
    check("wr_queue_drained", exp_wr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
